// File: rtl/fcmplt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fcmplt_pkg
//  Description : Shared definitions for the FloPoCo 12-bit floating-point
//                word (wE=5, wF=4): field widths, exception codes and the
//                word type used by the comparator and its scheduler.
//                Word layout: exc[11:10] sign[9] exp[8:4] frac[3:0]
//  Revision    : 1.0  initial release
// ============================================================================
package fcmplt_pkg;

    localparam int FP_W = 12;
    localparam int WE   = 5;
    localparam int WF   = 4;

    localparam logic [1:0] EXC_ZERO   = 2'b00;
    localparam logic [1:0] EXC_NORMAL = 2'b01;
    localparam logic [1:0] EXC_INF    = 2'b10;
    localparam logic [1:0] EXC_NAN    = 2'b11;

    typedef logic [11:0] fp12_t;

endpackage : fcmplt_pkg
`default_nettype wire

// File: rtl/fcmplt.sv
`default_nettype none
// ============================================================================
//  Module      : fcmplt
//  Description : Combinational FloPoCo X<Y comparator for the 12-bit format.
//                NaN on either side gives unordered=1, xlty=0. Both zero
//                encodings compare equal; infinities order beyond all normals.
//  Ports       : i_x, i_y     operands (fp12_t)
//                o_xlty       X strictly less than Y (0 when unordered)
//                o_unordered  X or Y is NaN
//  Revision    : 1.0  initial release
// ============================================================================
module fcmplt
    import fcmplt_pkg::*;
(
    input  fp12_t i_x,
    input  fp12_t i_y,
    output logic  o_xlty,
    output logic  o_unordered
);

    // Map a word onto a signed integer whose order matches the real order.
    // Magnitude key = {exc, exp, frac} for normals (exp/frac already monotone),
    // a single value above every normal for infinity, and 0 for either zero.
    function automatic logic signed [12:0] order_key(input fp12_t v);
        logic [10:0] mag;
        mag = 11'd0;
        case (v[11:10])
            EXC_NORMAL: mag = {EXC_NORMAL, v[WE+WF-1:0]};
            EXC_INF:    mag = {EXC_INF, 9'd0};
            default:    mag = 11'd0;
        endcase
        return v[WE+WF] ? -$signed({2'b00, mag}) : $signed({2'b00, mag});
    endfunction

    logic w_nan;

    assign w_nan       = (i_x[11:10] == EXC_NAN) || (i_y[11:10] == EXC_NAN);
    assign o_unordered = w_nan;
    assign o_xlty      = ~w_nan && (order_key(i_x) < order_key(i_y));

endmodule : fcmplt
`default_nettype wire

// File: rtl/fcmplt_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : fcmplt_rr_pick
//  Description : Round-robin one-hot picker. Searches the eligible vector
//                starting at i_ptr and wrapping NREQ-1 -> 0.
//  Ports       : i_eligible   requesters that may be granted
//                i_ptr        search start index
//                o_grant      one-hot grant (0 when nothing eligible)
//                o_grant_idx  index of the granted requester
//                o_grant_any  a grant was made
//  Revision    : 1.0  initial release
// ============================================================================
module fcmplt_rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         i_eligible,
    input  logic [$clog2(NREQ)-1:0] i_ptr,
    output logic [NREQ-1:0]         o_grant,
    output logic [$clog2(NREQ)-1:0] o_grant_idx,
    output logic                    o_grant_any
);

    localparam int c_IDX_W = $clog2(NREQ);
    localparam int c_SUM_W = c_IDX_W + 1;

    logic [c_SUM_W-1:0] w_pos;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_grant_any = 1'b0;
        w_pos       = '0;
        for (int k = 0; k < NREQ; k++) begin
            // ptr + k never exceeds 2*NREQ-2, so one conditional subtract wraps it
            w_pos = {1'b0, i_ptr} + c_SUM_W'(k);
            if (w_pos >= c_SUM_W'(NREQ)) begin
                w_pos = w_pos - c_SUM_W'(NREQ);
            end
            if (!o_grant_any && i_eligible[w_pos[c_IDX_W-1:0]]) begin
                o_grant_any                  = 1'b1;
                o_grant_idx                  = w_pos[c_IDX_W-1:0];
                o_grant[w_pos[c_IDX_W-1:0]] = 1'b1;
            end
        end
    end

endmodule : fcmplt_rr_pick
`default_nettype wire

// File: rtl/fcmplt_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : fcmplt_rr_sched
//  Description : Shares one fcmplt comparator among NREQ requesters with a
//                round-robin issue of at most one compare per cycle, a
//                PIPE-register result path and a held valid/ready response
//                slot per requester. Each requester has at most one
//                outstanding compare, so the pipeline never stalls.
//  Ports       : clk, rst                 clock, synchronous active-high reset
//                req_valid/req_ready      request handshake (ready one-hot)
//                req_x/req_y              operands, slice i = [i*FP_W +: FP_W]
//                rsp_valid/rsp_ready      response handshake per requester
//                rsp_xlty/rsp_unordered   held compare flags
//                busy                     any requester outstanding
//                stat_issued/stat_unordered (FCMPLT_SCHED_STATS_EN only)
//  Options     : FCMPLT_SCHED_STATS_EN adds wrapping 32-bit counters of
//                accepts and of unordered results delivered at handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module fcmplt_rr_sched #(
    parameter int NREQ = 4,
    parameter int PIPE = 2,
    parameter int FP_W = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*FP_W-1:0] req_x,
    input  logic [NREQ*FP_W-1:0] req_y,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [NREQ-1:0]      rsp_xlty,
    output logic [NREQ-1:0]      rsp_unordered,
`ifdef FCMPLT_SCHED_STATS_EN
    output logic [31:0]          stat_issued,
    output logic [31:0]          stat_unordered,
`endif
    output logic                 busy
);

    import fcmplt_pkg::*;

    localparam int c_IDX_W = $clog2(NREQ);

    logic [NREQ-1:0]    r_pend, w_elig, w_grant, w_rsp_hs;
    logic [NREQ-1:0]    r_rsp_valid, r_rsp_lt, r_rsp_un;
    logic [c_IDX_W-1:0] r_ptr, w_gidx, w_fin_tag;
    logic               w_any, w_accept;
    logic [FP_W-1:0]    w_sel_x, w_sel_y;
    logic               w_fin_v, w_fin_lt, w_fin_un;

    // ---------------- issue ----------------
    assign w_elig = req_valid & ~r_pend;

    fcmplt_rr_pick #(.NREQ(NREQ)) u_pick (
        .i_eligible  (w_elig),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_gidx),
        .o_grant_any (w_any)
    );

    assign req_ready = rst ? '0 : w_grant;
    assign w_accept  = w_any & ~rst;
    assign w_sel_x   = req_x[w_gidx*FP_W +: FP_W];
    assign w_sel_y   = req_y[w_gidx*FP_W +: FP_W];
    assign w_rsp_hs  = r_rsp_valid & rsp_ready;

    // pend set on accept and cleared on response handshake; the two can never
    // hit the same bit in one cycle because accept requires pend=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr  <= '0;
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend | req_ready) & ~w_rsp_hs;
            if (w_accept) begin
                r_ptr <= (w_gidx == c_IDX_W'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
            end
        end
    end

    // ---------------- result pipeline ----------------
    // Registers between the accept edge and the response slot: the slot is the
    // last of the PIPE stages, so PIPE-1 stages sit in front of it.
    generate
        if (PIPE == 1) begin : g_pipe_direct
            fcmplt u_cmp (
                .i_x         (fp12_t'(w_sel_x)),
                .i_y         (fp12_t'(w_sel_y)),
                .o_xlty      (w_fin_lt),
                .o_unordered (w_fin_un)
            );
            assign w_fin_v   = w_accept;
            assign w_fin_tag = w_gidx;
        end else begin : g_pipe_regs
            logic               r_s0_v;
            logic [c_IDX_W-1:0] r_s0_tag;
            logic [FP_W-1:0]    r_s0_x, r_s0_y;
            logic               w_s0_lt, w_s0_un;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s0_v <= 1'b0;
                end else begin
                    r_s0_v <= w_accept;
                end
                r_s0_tag <= w_gidx;
                r_s0_x   <= w_sel_x;
                r_s0_y   <= w_sel_y;
            end

            fcmplt u_cmp (
                .i_x         (fp12_t'(r_s0_x)),
                .i_y         (fp12_t'(r_s0_y)),
                .o_xlty      (w_s0_lt),
                .o_unordered (w_s0_un)
            );

            if (PIPE == 2) begin : g_no_delay
                assign w_fin_v   = r_s0_v;
                assign w_fin_tag = r_s0_tag;
                assign w_fin_lt  = w_s0_lt;
                assign w_fin_un  = w_s0_un;
            end else begin : g_delay
                localparam int c_ND = PIPE - 2;
                logic [c_ND-1:0]    r_d_v, r_d_lt, r_d_un;
                logic [c_IDX_W-1:0] r_d_tag [c_ND];

                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_d_v <= '0;
                    end else begin
                        r_d_v[0] <= r_s0_v;
                        for (int k = 1; k < c_ND; k++) begin
                            r_d_v[k] <= r_d_v[k-1];
                        end
                    end
                    r_d_tag[0] <= r_s0_tag;
                    r_d_lt[0]  <= w_s0_lt;
                    r_d_un[0]  <= w_s0_un;
                    for (int k = 1; k < c_ND; k++) begin
                        r_d_tag[k] <= r_d_tag[k-1];
                        r_d_lt[k]  <= r_d_lt[k-1];
                        r_d_un[k]  <= r_d_un[k-1];
                    end
                end

                assign w_fin_v   = r_d_v[c_ND-1];
                assign w_fin_tag = r_d_tag[c_ND-1];
                assign w_fin_lt  = r_d_lt[c_ND-1];
                assign w_fin_un  = r_d_un[c_ND-1];
            end
        end
    endgenerate

    // ---------------- response slots ----------------
    // A slot is only written by a result for its own requester, which pend
    // guarantees is empty, so held flags stay stable until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= '0;
            r_rsp_lt    <= '0;
            r_rsp_un    <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_fin_v && (w_fin_tag == c_IDX_W'(i))) begin
                    r_rsp_valid[i] <= 1'b1;
                    r_rsp_lt[i]    <= w_fin_lt;
                    r_rsp_un[i]    <= w_fin_un;
                end else if (w_rsp_hs[i]) begin
                    r_rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign rsp_valid     = r_rsp_valid;
    assign rsp_xlty      = r_rsp_lt;
    assign rsp_unordered = r_rsp_un;
    assign busy          = |r_pend;

`ifdef FCMPLT_SCHED_STATS_EN
    logic [31:0] r_stat_issued, r_stat_unord, w_unord_cnt;

    // several requesters may consume unordered results in the same cycle
    always_comb begin
        w_unord_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_unord_cnt = w_unord_cnt + {31'd0, w_rsp_hs[i] & r_rsp_un[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_issued <= '0;
            r_stat_unord  <= '0;
        end else begin
            r_stat_issued <= r_stat_issued + {31'd0, w_accept};
            r_stat_unord  <= r_stat_unord + w_unord_cnt;
        end
    end

    assign stat_issued    = r_stat_issued;
    assign stat_unordered = r_stat_unord;
`endif

endmodule : fcmplt_rr_sched
`default_nettype wire

// File: tb/tb_fcmplt_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fcmplt_rr_sched
//  Description : Self-checking bench for fcmplt_rr_sched (NREQ=4, PIPE=2).
//                Directed scenarios plus a randomized run against a
//                real-valued reference comparator and a round-robin model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fcmplt_rr_sched;

    localparam int NREQ = 4;
    localparam int PIPE = 2;
    localparam int FP_W = 12;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NREQ-1:0]      rsp_xlty, rsp_unordered;
    logic [NREQ*FP_W-1:0] req_x, req_y;
    logic                 busy;
`ifdef FCMPLT_SCHED_STATS_EN
    logic [31:0]          stat_issued, stat_unordered;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fcmplt_rr_sched #(.NREQ(NREQ), .PIPE(PIPE), .FP_W(FP_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_x         (req_x),
        .req_y         (req_y),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_xlty      (rsp_xlty),
        .rsp_unordered (rsp_unordered),
`ifdef FCMPLT_SCHED_STATS_EN
        .stat_issued   (stat_issued),
        .stat_unordered(stat_unordered),
`endif
        .busy          (busy)
    );

    // ---------------- reference arithmetic ----------------
    function automatic bit ref_nan(input logic [11:0] v);
        return v[11:10] == 2'b11;
    endfunction

    function automatic real ref_value(input logic [11:0] v);
        real m;
        int  e;
        if (v[11:10] == 2'b00) return 0.0;
        if (v[11:10] == 2'b10) m = 1.0e300;
        else begin
            m = 1.0 + real'(v[3:0]) / 16.0;
            e = int'(v[8:4]) - 15;
            while (e > 0) begin m = m * 2.0; e--; end
            while (e < 0) begin m = m / 2.0; e++; end
        end
        return v[9] ? -m : m;
    endfunction

    function automatic bit ref_lt(input logic [11:0] x, input logic [11:0] y);
        if (ref_nan(x) || ref_nan(y)) return 1'b0;
        return ref_value(x) < ref_value(y);
    endfunction

    function automatic logic [11:0] rand_fp();
        logic [11:0] v;
        int          sel;
        v   = 12'($urandom);
        sel = int'($urandom_range(0, 9));
        if (sel == 0)      v[11:10] = 2'b00;
        else if (sel <= 6) v[11:10] = 2'b01;
        else if (sel <= 8) v[11:10] = 2'b10;
        else               v[11:10] = 2'b11;
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic set_op(input int i, input logic [11:0] x, input logic [11:0] y);
        req_x[i*FP_W +: FP_W] = x;
        req_y[i*FP_W +: FP_W] = y;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        req_valid = '1;
        rsp_ready = '1;
        for (int i = 0; i < NREQ; i++) set_op(i, 12'h4F0, 12'h500);
        step();
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_ready got %b want 0000", req_ready);
        end
        checks++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_rsp got valid=%b busy=%b want 0000/0", rsp_valid, busy);
        end
        do_reset();
        #1;
        checks++;
        if (rsp_xlty !== 4'b0000 || rsp_unordered !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b/%b want 0000/0000", rsp_xlty, rsp_unordered);
        end
`ifdef FCMPLT_SCHED_STATS_EN
        checks++;
        if (stat_issued !== 32'd0 || stat_unordered !== 32'd0) begin
            errors++; $display("FAIL reset_stats got %0d/%0d want 0/0", stat_issued, stat_unordered);
        end
`endif
    endtask

    task automatic test_basic();
        do_reset();
        rsp_ready = '1;
        set_op(0, 12'h4F0, 12'h500);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL basic_grant got %b want 0001", req_ready);
        end
        step();
        req_valid = '0;
        #1;
        checks++;
        if (rsp_valid !== 4'b0000) begin
            errors++; $display("FAIL basic_early got %b want 0000", rsp_valid);
        end
        step();
        #1;
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_xlty[0] !== 1'b1 || rsp_unordered[0] !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL basic_rsp got v=%b lt=%b un=%b busy=%b want 0001/1/0/1",
                               rsp_valid, rsp_xlty[0], rsp_unordered[0], busy);
        end
        step();
        #1;
        checks++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_drain got v=%b busy=%b want 0000/0", rsp_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [NREQ-1:0] exp_ready, exp_rv;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, 12'h4F0, 12'h500);
        req_valid = '1;
        for (int c = 0; c < 6; c++) begin
            #1;
            exp_ready = (c < NREQ) ? NREQ'(1 << c) : '0;
            exp_rv    = '0;
            for (int j = 0; j < NREQ; j++) if (j + PIPE <= c) exp_rv[j] = 1'b1;
            checks++;
            if (req_ready !== exp_ready || rsp_valid !== exp_rv) begin
                errors++; $display("FAIL rr_cycle%0d got ready=%b valid=%b want %b/%b",
                                   c, req_ready, rsp_valid, exp_ready, exp_rv);
            end
            step();
        end
        for (int i = 0; i < NREQ; i++) begin
            rsp_ready = NREQ'(1 << i);
            #1;
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++; $display("FAIL rr_same_cycle%0d got %b want 0000", i, req_ready);
            end
            step();
            rsp_ready = '0;
            #1;
            checks++;
            if (req_ready !== NREQ'(1 << i) || rsp_valid[i] !== 1'b0) begin
                errors++; $display("FAIL rr_regrant%0d got ready=%b valid=%b want %b/0",
                                   i, req_ready, rsp_valid[i], NREQ'(1 << i));
            end
            step();
        end
        req_valid = '0;
    endtask

    task automatic test_compare();
        logic [11:0] tx [8] = '{12'h4F0, 12'hC00, 12'h200, 12'h6F0, 12'hA00, 12'h500, 12'h4F0, 12'h4F0};
        logic [11:0] ty [8] = '{12'h500, 12'h4F0, 12'h000, 12'h800, 12'h800, 12'h4F0, 12'hC00, 12'h4F0};
        logic [1:0]  te [8] = '{2'b10,   2'b01,   2'b00,   2'b10,   2'b10,   2'b00,   2'b01,   2'b00};
        do_reset();
        rsp_ready = '1;
        for (int k = 0; k < 8; k++) begin
            set_op(0, tx[k], ty[k]);
            req_valid = 4'b0001;
            step();
            req_valid = '0;
            step();
            #1;
            checks++;
            if (rsp_valid[0] !== 1'b1 || {rsp_xlty[0], rsp_unordered[0]} !== te[k]) begin
                errors++; $display("FAIL cmp_%03h_%03h got v=%b lt,un=%b want 1/%b",
                                   tx[k], ty[k], rsp_valid[0], {rsp_xlty[0], rsp_unordered[0]}, te[k]);
            end
            step();
        end
    endtask

    task automatic test_hold();
        int gcount [NREQ];
        for (int j = 0; j < NREQ; j++) gcount[j] = 0;
        do_reset();
        set_op(0, 12'hC00, 12'h4F0);
        for (int i = 1; i < NREQ; i++) set_op(i, 12'h4F0, 12'h500);
        rsp_ready = 4'b1110;
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL hold_first got %b want 0001", req_ready);
        end
        for (int c = 1; c <= 10; c++) begin
            step();
            #1;
            for (int j = 0; j < NREQ; j++) gcount[j] += int'(req_ready[j]);
            checks++;
            if (req_ready[0] !== 1'b0) begin
                errors++; $display("FAIL hold_ready0_c%0d got 1 want 0", c);
            end
            if (c >= PIPE) begin
                checks++;
                if ({rsp_valid[0], rsp_xlty[0], rsp_unordered[0]} !== 3'b101) begin
                    errors++; $display("FAIL hold_stable_c%0d got %b want 101", c,
                                       {rsp_valid[0], rsp_xlty[0], rsp_unordered[0]});
                end
            end
        end
        for (int j = 1; j < NREQ; j++) begin
            checks++;
            if (gcount[j] == 0) begin
                errors++; $display("FAIL hold_served%0d got 0 grants want >0", j);
            end
        end
        req_valid = 4'b0001;
        rsp_ready = 4'b1111;
        #1;
        checks++;
        if (req_ready[0] !== 1'b0) begin
            errors++; $display("FAIL hold_release_same got 1 want 0");
        end
        step();
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL hold_regrant got %b want 0001", req_ready);
        end
        step();
        req_valid = '0;
        repeat (4) step();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, 12'h4F0, 12'h500);
        req_valid = '1;
        repeat (3) step();
        req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++;
            if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
                errors++; $display("FAIL flush_c%0d got v=%b busy=%b want 0000/0", c, rsp_valid, busy);
            end
            step();
        end
        req_valid = '1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL flush_ptr got %b want 0001", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_random();
        int          ptr;
        bit          pend [NREQ];
        int          arr  [NREQ];
        bit          m_lt [NREQ];
        bit          m_un [NREQ];
        logic [NREQ-1:0] exp_ready, exp_rv;
        bit          exp_busy;
        int          g;
        logic [11:0] x, y;
        int          issued, unord;
        ptr = 0; issued = 0; unord = 0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 0; arr[i] = 0; m_lt[i] = 0; m_un[i] = 0;
        end
        do_reset();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                req_valid[i] = ($urandom_range(0, 9) < 7);
                rsp_ready[i] = ($urandom_range(0, 9) < 6);
                x = rand_fp();
                y = ($urandom_range(0, 4) == 0) ? x : rand_fp();
                set_op(i, x, y);
            end
            #1;
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (ptr + k) % NREQ;
                if (g < 0 && req_valid[j] && !pend[j]) g = j;
            end
            exp_ready = (g >= 0) ? NREQ'(1 << g) : '0;
            exp_rv    = '0;
            exp_busy  = 0;
            for (int i = 0; i < NREQ; i++) begin
                exp_rv[i] = pend[i] && (n >= arr[i]);
                exp_busy  = exp_busy | pend[i];
            end
            checks++;
            if (req_ready !== exp_ready || rsp_valid !== exp_rv || busy !== exp_busy) begin
                errors++; $display("FAIL rand_n%0d got rdy=%b v=%b busy=%b want %b/%b/%b",
                                   n, req_ready, rsp_valid, busy, exp_ready, exp_rv, exp_busy);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (exp_rv[i]) begin
                    checks++;
                    if (rsp_xlty[i] !== m_lt[i] || rsp_unordered[i] !== m_un[i]) begin
                        errors++; $display("FAIL rand_flags_n%0d_r%0d got %b%b want %b%b",
                                           n, i, rsp_xlty[i], rsp_unordered[i], m_lt[i], m_un[i]);
                    end
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (exp_rv[i] && rsp_ready[i]) begin
                    pend[i] = 0;
                    if (m_un[i]) unord++;
                end
            end
            if (g >= 0) begin
                x       = req_x[g*FP_W +: FP_W];
                y       = req_y[g*FP_W +: FP_W];
                pend[g] = 1;
                arr[g]  = n + PIPE;
                m_un[g] = ref_nan(x) || ref_nan(y);
                m_lt[g] = ref_lt(x, y);
                ptr     = (g + 1) % NREQ;
                issued++;
            end
            step();
        end
`ifdef FCMPLT_SCHED_STATS_EN
        #1;
        checks++;
        if (stat_issued !== 32'(issued) || stat_unordered !== 32'(unord)) begin
            errors++; $display("FAIL rand_stats got %0d/%0d want %0d/%0d",
                               stat_issued, stat_unordered, issued, unord);
        end
`endif
        clear_inputs();
    endtask

`ifdef FCMPLT_SCHED_STATS_EN
    task automatic test_stats();
        logic [11:0] sx [5] = '{12'h4F0, 12'hC00, 12'h500, 12'h4F0, 12'h6F0};
        logic [11:0] sy [5] = '{12'h500, 12'h4F0, 12'h4F0, 12'hC00, 12'h800};
        do_reset();
        rsp_ready = '1;
        for (int k = 0; k < 5; k++) begin
            set_op(k % NREQ, sx[k], sy[k]);
            req_valid = NREQ'(1 << (k % NREQ));
            step();
            req_valid = '0;
        end
        repeat (4) step();
        #1;
        checks++;
        if (stat_issued !== 32'd5 || stat_unordered !== 32'd2) begin
            errors++; $display("FAIL stats got %0d/%0d want 5/2", stat_issued, stat_unordered);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_basic();
        test_back_to_back();
        test_compare();
        test_hold();
        test_reset_midflight();
        test_random();
`ifdef FCMPLT_SCHED_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fcmplt_rr_sched
`default_nettype wire
